// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED mode controller: mode codes, FSM states and
// the seed pattern each mode starts from.
package led_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_ROT_L    = 2'd0,
      MODE_ROT_R    = 2'd1,
      MODE_BLINK    = 2'd2,
      MODE_PINGPONG = 2'd3
   } led_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } led_state_e;

   localparam logic [3:0] SEED_ROT_L    = 4'b0001;
   localparam logic [3:0] SEED_ROT_R    = 4'b1000;
   localparam logic [3:0] SEED_BLINK    = 4'b1111;
   localparam logic [3:0] SEED_PINGPONG = 4'b0001;

   function automatic logic [3:0] mode_seed(input led_mode_e mode);
      case (mode)
         MODE_ROT_L:    return SEED_ROT_L;
         MODE_ROT_R:    return SEED_ROT_R;
         MODE_BLINK:    return SEED_BLINK;
         default:       return SEED_PINGPONG;
      endcase
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step-tick generator: free-running 0..TICK_MAX counter with clear and enable;
// tick marks the enabled cycle in which the count sits at TICK_MAX.
module led_tick_gen #(
   parameter logic [23:0] TICK_MAX = 24'd9_999_999
) (
   input  logic sys_clk,
   input  logic sys_res,
   input  logic clr,
   input  logic en,
   output logic tick
);

   logic [23:0] cnt;

   always_ff @(posedge sys_clk) begin
      if (sys_res || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == TICK_MAX) ? '0 : cnt + 24'd1;
      end
   end

   assign tick = en && (cnt == TICK_MAX);

endmodule

// File: rtl/led_mode_ctrl.sv
// LED pattern controller: round-robin arbitration of mode-change requests and
// an IDLE/RUN/PAUSE pattern engine stepped by led_tick_gen.
module led_mode_ctrl
   import led_ctrl_pkg::*;
#(
   parameter logic [23:0] TICK_MAX = 24'd9_999_999,
   parameter int          NREQ     = 3
) (
   input  logic              sys_clk,
   input  logic              sys_res,
   input  logic [NREQ-1:0]   req,
   input  logic [2*NREQ-1:0] req_mode,
   input  logic              pause_tgl,
   output logic [NREQ-1:0]   grant,
   output logic [3:0]        led,
   output logic [1:0]        cur_mode,
   output logic              busy
);

   led_state_e      state;
   logic            dir_right;
   logic [1:0]      ptr;
   logic [2:0]      cand;
   logic [1:0]      idx;
   logic            gnt_valid;
   logic [1:0]      gnt_idx;
   led_mode_e       gnt_mode;
   logic [NREQ-1:0] gnt_vec;
   logic            tick;
   logic            cnt_clr;
   logic            cnt_en;

   // First asserted request found scanning upward from ptr, wrapping at NREQ.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      gnt_mode  = MODE_ROT_L;
      gnt_vec   = '0;
      cand      = '0;
      idx       = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = {1'b0, ptr} + 3'(k);
         if (cand >= 3'(NREQ)) cand = cand - 3'(NREQ);
         idx = cand[1:0];
         if (!gnt_valid && req[idx]) begin
            gnt_valid    = 1'b1;
            gnt_idx      = idx;
            gnt_mode     = led_mode_e'(req_mode[{idx, 1'b0} +: 2]);
            gnt_vec[idx] = 1'b1;
         end
      end
   end

   assign cnt_clr = gnt_valid || (state == ST_IDLE);
   assign cnt_en  = (state == ST_RUN);

   led_tick_gen #(.TICK_MAX(TICK_MAX)) u_tick (
      .sys_clk (sys_clk),
      .sys_res (sys_res),
      .clr     (cnt_clr),
      .en      (cnt_en),
      .tick    (tick)
   );

   always_ff @(posedge sys_clk) begin
      if (sys_res) begin
         state     <= ST_IDLE;
         led       <= '0;
         cur_mode  <= '0;
         grant     <= '0;
         ptr       <= '0;
         dir_right <= 1'b0;
         busy      <= 1'b0;
      end else begin
         grant <= gnt_vec;
         // A grant overrides both the pending step and any pause toggle.
         if (gnt_valid) begin
            cur_mode  <= gnt_mode;
            led       <= mode_seed(gnt_mode);
            dir_right <= 1'b0;
            state     <= ST_RUN;
            busy      <= 1'b1;
            ptr       <= (gnt_idx == 2'(NREQ - 1)) ? 2'd0 : gnt_idx + 2'd1;
         end else begin
            unique case (state)
               ST_IDLE: led <= '0;
               ST_RUN: begin
                  if (tick) begin
                     case (led_mode_e'(cur_mode))
                        MODE_ROT_L: led <= {led[2:0], led[3]};
                        MODE_ROT_R: led <= {led[0], led[3:1]};
                        MODE_BLINK: led <= ~led;
                        MODE_PINGPONG: begin
                           if (!dir_right) begin
                              if (led[3]) begin
                                 led       <= 4'b0100;
                                 dir_right <= 1'b1;
                              end else begin
                                 led <= led << 1;
                              end
                           end else if (led[0]) begin
                              led       <= 4'b0010;
                              dir_right <= 1'b0;
                           end else begin
                              led <= led >> 1;
                           end
                        end
                     endcase
                  end
                  if (pause_tgl) begin
                     state <= ST_PAUSE;
                     busy  <= 1'b0;
                  end
               end
               ST_PAUSE: begin
                  if (pause_tgl) begin
                     state <= ST_RUN;
                     busy  <= 1'b1;
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Self-checking bench for led_mode_ctrl with TICK_MAX = 3: vector table,
// directed corner sequences and randomized traffic against a step-count model.
module tb_led_mode_ctrl;

   logic       sys_clk = 1'b0;
   logic       sys_res = 1'b1;
   logic [2:0] req = '0;
   logic [5:0] req_mode = '0;
   logic       pause_tgl = 1'b0;
   logic [2:0] grant;
   logic [3:0] led;
   logic [1:0] cur_mode;
   logic       busy;

   always #5 sys_clk = ~sys_clk;

   led_mode_ctrl #(.TICK_MAX(24'd3), .NREQ(3)) dut (
      .sys_clk   (sys_clk),
      .sys_res   (sys_res),
      .req       (req),
      .req_mode  (req_mode),
      .pause_tgl (pause_tgl),
      .grant     (grant),
      .led       (led),
      .cur_mode  (cur_mode),
      .busy      (busy)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Model: pattern is tracked as the number of steps taken since the seed.
   int         m_state;   // 0 idle, 1 run, 2 pause
   int         m_mode;
   int         m_pos;
   int         m_cnt;
   int         m_last;
   logic [2:0] m_grant;

   function automatic logic [3:0] pattern(input int mode, input int pos);
      case (mode)
         0: return 4'(1 << (pos % 4));
         1: return 4'(8 >> (pos % 4));
         2: return ((pos % 2) == 0) ? 4'hF : 4'h0;
         default: begin
            case (pos % 6)
               0: return 4'b0001;
               1: return 4'b0010;
               2: return 4'b0100;
               3: return 4'b1000;
               4: return 4'b0100;
               default: return 4'b0010;
            endcase
         end
      endcase
   endfunction

   function automatic logic [3:0] m_led();
      return (m_state == 0) ? 4'b0000 : pattern(m_mode, m_pos);
   endfunction

   task automatic model_step();
      int gi;
      if (sys_res) begin
         m_state = 0; m_mode = 0; m_pos = 0; m_cnt = 0; m_last = 2; m_grant = '0;
         return;
      end
      gi = -1;
      for (int k = 0; k < 3; k++) begin
         int i;
         i = (m_last + 1 + k) % 3;
         if (gi < 0 && req[i]) gi = i;
      end
      if (gi >= 0) begin
         m_grant = 3'(1 << gi);
         m_mode  = int'(req_mode[2*gi +: 2]);
         m_pos   = 0;
         m_cnt   = 0;
         m_state = 1;
         m_last  = gi;
      end else begin
         m_grant = '0;
         case (m_state)
            0: m_cnt = 0;
            1: begin
               if (m_cnt == 3) begin
                  m_pos++;
                  m_cnt = 0;
               end else begin
                  m_cnt++;
               end
               if (pause_tgl) m_state = 2;
            end
            default: if (pause_tgl) m_state = 1;
         endcase
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic cyc(input bit use_model);
      @(posedge sys_clk);
      model_step();
      @(negedge sys_clk);
      if (use_model) begin
         check("rnd_grant", 32'(grant), 32'(m_grant));
         check("rnd_led", 32'(led), 32'(m_led()));
         check("rnd_mode", 32'(cur_mode), 32'(m_mode));
         check("rnd_busy", 32'(busy), 32'(m_state == 1));
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0);
   endtask

   typedef struct {
      logic       res;
      logic [2:0] rq;
      logic [5:0] rm;
      logic       tg;
      logic [2:0] g;
      logic [3:0] l;
      logic [1:0] m;
      logic       b;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic res, input logic [2:0] rq, input logic [5:0] rm,
                               input logic tg, input logic [2:0] g, input logic [3:0] l,
                               input logic [1:0] m, input logic b);
      vec_t v;
      v.res = res; v.rq = rq; v.rm = rm; v.tg = tg;
      v.g = g; v.l = l; v.m = m; v.b = b;
      tbl.push_back(v);
   endfunction

   logic [3:0] rot_seq [5];
   logic [3:0] pp_seq [6];

   initial begin
      // Table: reset, toggle ignored in IDLE, then ROT_L with 4-cycle steps.
      rot_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      add(1'b1, 3'b000, 6'd0, 1'b0, 3'b000, 4'b0000, 2'd0, 1'b0);
      add(1'b0, 3'b000, 6'd0, 1'b1, 3'b000, 4'b0000, 2'd0, 1'b0);
      add(1'b0, 3'b001, 6'd0, 1'b0, 3'b001, 4'b0001, 2'd0, 1'b1);
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < 4; c++) begin
            add(1'b0, 3'b000, 6'd0, 1'b0, 3'b000,
                (c == 3) ? rot_seq[s+1] : rot_seq[s], 2'd0, 1'b1);
         end
      end
      foreach (tbl[i]) begin
         sys_res = tbl[i].res; req = tbl[i].rq; req_mode = tbl[i].rm; pause_tgl = tbl[i].tg;
         cyc(1'b0);
         check("tbl_grant", 32'(grant), 32'(tbl[i].g));
         check("tbl_led", 32'(led), 32'(tbl[i].l));
         check("tbl_mode", 32'(cur_mode), 32'(tbl[i].m));
         check("tbl_busy", 32'(busy), 32'(tbl[i].b));
      end
      req = '0; pause_tgl = 1'b0;

      // Round-robin order with all three requesting.
      sys_res = 1'b1;
      cyc(1'b0);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_led", 32'(led), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      sys_res = 1'b0;
      req = 3'b111; req_mode = 6'b11_10_01;
      cyc(1'b0);
      check("rr_g0", 32'(grant), 32'b001);
      check("rr_m0", 32'(cur_mode), 32'd1);
      check("rr_seed_rotr", 32'(led), 32'b1000);
      req[0] = 1'b0;
      cyc(1'b0);
      check("rr_g1", 32'(grant), 32'b010);
      check("rr_seed_blink", 32'(led), 32'b1111);
      req[1] = 1'b0;
      cyc(1'b0);
      check("rr_g2", 32'(grant), 32'b100);
      check("rr_m2", 32'(cur_mode), 32'd3);
      check("pp_seed", 32'(led), 32'b0001);
      req = '0;
      cyc(1'b0);
      check("rr_none", 32'(grant), 32'd0);

      // PINGPONG reversal at both ends.
      pp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
      run(2);
      for (int s = 0; s < 6; s++) begin
         cyc(1'b0);
         check("pp_step", 32'(led), 32'(pp_seq[s]));
         if (s < 5) run(3);
      end

      // Reset mid-pattern.
      run(2);
      sys_res = 1'b1;
      cyc(1'b0);
      check("mid_rst_led", 32'(led), 32'd0);
      check("mid_rst_mode", 32'(cur_mode), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_grant", 32'(grant), 32'd0);
      sys_res = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0);
         check("post_rst_grant", 32'(grant), 32'd0);
         check("post_rst_led", 32'(led), 32'd0);
      end

      // Pause at count 1, hold 20 cycles, resume.
      req = 3'b001; req_mode = 6'd0;
      cyc(1'b0);
      check("pz_grant", 32'(grant), 32'b001);
      req = '0;
      cyc(1'b0);
      pause_tgl = 1'b1;
      cyc(1'b0);
      check("pz_busy", 32'(busy), 32'd0);
      pause_tgl = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc(1'b0);
         check("pz_led_frozen", 32'(led), 32'b0001);
         check("pz_busy_low", 32'(busy), 32'd0);
      end
      pause_tgl = 1'b1;
      cyc(1'b0);
      check("resume_busy", 32'(busy), 32'd1);
      pause_tgl = 1'b0;
      cyc(1'b0);
      check("resume_wait", 32'(led), 32'b0001);
      cyc(1'b0);
      check("resume_step", 32'(led), 32'b0010);

      // Grant on the tick cycle: new seed wins, no rotation.
      run(3);
      cyc(1'b0);
      check("pre_tick_led", 32'(led), 32'b0100);
      run(3);
      req = 3'b010; req_mode = 6'b00_01_00;
      cyc(1'b0);
      check("tick_grant", 32'(grant), 32'b010);
      check("tick_grant_led", 32'(led), 32'b1000);
      check("tick_grant_mode", 32'(cur_mode), 32'd1);
      req = '0;
      cyc(1'b0);
      check("tick_grant_hold", 32'(led), 32'b1000);

      // Randomized traffic against the model.
      sys_res = 1'b1;
      run(2);
      sys_res = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         cyc(1'b1);
         n_cmp++;
         if ($countones(grant) > 1) begin
            n_bad++;
            $display("FAIL rnd_onehot at %0t: got %b required at most one bit", $time, grant);
         end
         sys_res = ($urandom_range(0, 199) == 0);
         pause_tgl = ($urandom_range(0, 9) == 0);
         for (int i = 0; i < 3; i++) begin
            if (m_grant[i]) begin
               req[i] = 1'b0;
            end else if (!req[i] && $urandom_range(0, 11) == 0) begin
               req[i] = 1'b1;
               req_mode[2*i +: 2] = 2'($urandom_range(0, 3));
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
